// File: rtl/stack_proc_pkg.sv
// Shared types and constants for the stack processor front end.
package stack_proc_pkg;

  localparam int INST_W = 16;
  localparam int PC_W   = 16;

  localparam logic [PC_W-1:0] PC_STEP          = 16'd2;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } fetch_state_t;

  // Redirect targets are forced even so an odd byte address is never fetched.
  function automatic logic [PC_W-1:0] align_target(input logic [PC_W-1:0] target);
    return target & ~16'h0001;
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_unit.sv
// Program counter register with sequential / redirect next-PC selection.
module pc_unit
  import stack_proc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            accept,
  input  logic            PCWrite,
  input  logic [PC_W-1:0] newPC,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_next;

  always_comb begin
    pc_next = pc;
    if (accept) begin
      if (PCWrite) pc_next = align_target(newPC);
      else         pc_next = pc + PC_STEP;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= pc_next;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: FETCH/WAIT/VALID sequencing over a synchronous instruction memory.
module instruction_fetch
  import stack_proc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              IMEM_AW  = 13
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [PC_W-1:0]     newPC,
  input  logic                PCWrite,
  input  logic                inst_ready,
  input  logic [INST_W-1:0]   imem_dout,
  output logic [IMEM_AW-1:0]  imem_addr,
  output logic                imem_en,
  output logic [INST_W-1:0]   inst,
  output logic                inst_valid,
  output logic [PC_W-1:0]     pc
);

  fetch_state_t state, state_next;
  logic         accept;

  assign accept = inst_valid & inst_ready;

  pc_unit #(.RESET_PC(RESET_PC)) u_pc_unit (
    .CLK     (CLK),
    .reset   (reset),
    .accept  (accept),
    .PCWrite (PCWrite),
    .newPC   (newPC),
    .pc      (pc)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  state_next = FETCH;
      FETCH: state_next = WAIT;
      WAIT:  state_next = VALID;
      VALID: if (accept) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Memory-side outputs depend only on state and pc, never on inputs.
  always_comb begin
    imem_en   = (state == FETCH);
    imem_addr = pc[IMEM_AW:1];
  end

  // Read data is captured on the WAIT->VALID edge; reset during WAIT drops it.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      inst       <= '0;
      inst_valid <= 1'b0;
    end else if (state == WAIT) begin
      inst       <= imem_dout;
      inst_valid <= 1'b1;
    end else if (accept) begin
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a behavioural sync memory.
module tb_instruction_fetch;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] newPC = 16'h0000;
  logic        PCWrite = 1'b0;
  logic        inst_ready = 1'b0;
  logic [15:0] imem_dout = 16'h0000;
  logic [12:0] imem_addr;
  logic        imem_en;
  logic [15:0] inst;
  logic        inst_valid;
  logic [15:0] pc;

  logic [15:0] mem [0:8191];

  int vectors = 0;
  int miscompares = 0;

  instruction_fetch #(.RESET_PC(16'h0000), .IMEM_AW(13)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .newPC      (newPC),
    .PCWrite    (PCWrite),
    .inst_ready (inst_ready),
    .imem_dout  (imem_dout),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc)
  );

  always #5 CLK = ~CLK;

  // Synchronous instruction memory: data one cycle after address/enable.
  always @(posedge CLK) begin
    if (imem_en) imem_dout <= mem[imem_addr];
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkPresented(input string tag, input logic [15:0] exp_inst, input logic [15:0] exp_pc);
    checkOutput({tag, "_valid"}, {15'd0, inst_valid}, 16'h0001);
    checkOutput({tag, "_inst"}, inst, exp_inst);
    checkOutput({tag, "_pc"}, pc, exp_pc);
    checkOutput({tag, "_en"}, {15'd0, imem_en}, 16'h0000);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;

    // Reset and first fetch
    mem[0] = 16'hA123;
    tick();
    checkOutput("rst_pc", pc, 16'h0000);
    checkOutput("rst_valid", {15'd0, inst_valid}, 16'h0000);
    checkOutput("rst_en", {15'd0, imem_en}, 16'h0000);
    checkOutput("rst_inst", inst, 16'h0000);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("e1_en", {15'd0, imem_en}, 16'h0001);
    checkOutput("e1_addr", {3'd0, imem_addr}, 16'h0000);
    checkOutput("e1_valid", {15'd0, inst_valid}, 16'h0000);
    tick();
    checkOutput("e2_en", {15'd0, imem_en}, 16'h0000);
    checkOutput("e2_valid", {15'd0, inst_valid}, 16'h0000);
    tick();
    checkPresented("first", 16'hA123, 16'h0000);

    // Backpressure: nothing moves while inst_ready is low
    for (int i = 0; i < 10; i++) begin
      tick();
      checkPresented("hold", 16'hA123, 16'h0000);
    end

    // Sequential stream after a fresh reset
    for (int i = 0; i < 5; i++) mem[i] = 16'h1000 + 16'(i);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    inst_ready = 1'b1;
    tick();
    tick();
    tick();
    checkPresented("seq0", 16'h1000, 16'h0000);
    for (int k = 1; k < 4; k++) begin
      tick();
      checkOutput("seq_acc_en", {15'd0, imem_en}, 16'h0001);
      checkOutput("seq_acc_valid", {15'd0, inst_valid}, 16'h0000);
      checkOutput("seq_acc_addr", {3'd0, imem_addr}, 16'(k));
      tick();
      tick();
      checkPresented("seq", 16'h1000 + 16'(k), 16'(2 * k));
    end

    // Redirect request outside VALID is ignored
    tick();
    checkOutput("seq4_pc", pc, 16'h0008);
    PCWrite = 1'b1;
    newPC = 16'h0100;
    tick();
    checkOutput("ign_pc_fetch", pc, 16'h0008);
    inst_ready = 1'b0;
    tick();
    checkPresented("ign", 16'h1004, 16'h0008);

    // Redirect to an odd target
    mem[13'h020] = 16'hBEEF;
    newPC = 16'h0041;
    inst_ready = 1'b1;
    tick();
    checkOutput("redir_pc", pc, 16'h0040);
    checkOutput("redir_addr", {3'd0, imem_addr}, 16'h0020);
    checkOutput("redir_en", {15'd0, imem_en}, 16'h0001);
    PCWrite = 1'b0;
    inst_ready = 1'b0;
    tick();
    tick();
    checkPresented("redir", 16'hBEEF, 16'h0040);

    // Wrap from the top of the address space
    mem[13'h1FFF] = 16'h5A5A;
    PCWrite = 1'b1;
    newPC = 16'hFFFE;
    inst_ready = 1'b1;
    tick();
    checkOutput("wrap_pc", pc, 16'hFFFE);
    checkOutput("wrap_addr", {3'd0, imem_addr}, 16'h1FFF);
    PCWrite = 1'b0;
    inst_ready = 1'b0;
    tick();
    tick();
    checkPresented("wrap", 16'h5A5A, 16'hFFFE);
    inst_ready = 1'b1;
    tick();
    checkOutput("wrap_next_pc", pc, 16'h0000);
    checkOutput("wrap_next_addr", {3'd0, imem_addr}, 16'h0000);
    inst_ready = 1'b0;

    // Reset asserted in WAIT discards the in-flight read
    mem[0] = 16'hC0DE;
    tick();
    checkOutput("wait_en", {15'd0, imem_en}, 16'h0000);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst_valid", {15'd0, inst_valid}, 16'h0000);
    checkOutput("midrst_pc", pc, 16'h0000);
    checkOutput("midrst_inst", inst, 16'h0000);
    tick();
    checkOutput("midrst_hold_inst", inst, 16'h0000);
    checkOutput("midrst_hold_valid", {15'd0, inst_valid}, 16'h0000);
    reset = 1'b1;
    tick();
    checkOutput("restart_en", {15'd0, imem_en}, 16'h0001);
    tick();
    checkOutput("restart_e2_valid", {15'd0, inst_valid}, 16'h0000);
    tick();
    checkPresented("restart", 16'hC0DE, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
